// File: rtl/seg_pkg.sv
// Segment encodings shared by the BCD decoder and the display scanner.
// All patterns are active-low, ordered {a,b,c,d,e,f,g,dp}: bit 7 = a, bit 0 = dp.
package seg_pkg;

    localparam int unsigned SEG_W = 8;

    typedef logic [SEG_W-1:0] seg_t;

    // Bit position of each segment inside a seg_t pattern
    localparam int unsigned SEG_A_BIT  = 7;
    localparam int unsigned SEG_B_BIT  = 6;
    localparam int unsigned SEG_C_BIT  = 5;
    localparam int unsigned SEG_D_BIT  = 4;
    localparam int unsigned SEG_E_BIT  = 3;
    localparam int unsigned SEG_F_BIT  = 2;
    localparam int unsigned SEG_G_BIT  = 1;
    localparam int unsigned SEG_DP_BIT = 0;

    localparam seg_t SEG_0     = 8'b0000_0011;
    localparam seg_t SEG_1     = 8'b1001_1111;
    localparam seg_t SEG_2     = 8'b0010_0101;
    localparam seg_t SEG_3     = 8'b0000_1101;
    localparam seg_t SEG_4     = 8'b1001_1001;
    localparam seg_t SEG_5     = 8'b0100_1001;
    localparam seg_t SEG_6     = 8'b0100_0001;
    localparam seg_t SEG_7     = 8'b0001_1111;
    localparam seg_t SEG_8     = 8'b0000_0001;
    localparam seg_t SEG_9     = 8'b0001_1001;
    localparam seg_t SEG_ERR   = 8'b0110_0001;
    localparam seg_t SEG_BLANK = 8'b1111_1111;

endpackage

// File: rtl/bcd_seg_decode.sv
// Combinational BCD to active-low 7-segment decoder with decimal point and blanking.
// Ports:
//   code_i  : 4-bit BCD digit; 10..15 show the "E" glyph
//   dp_i    : 1 lights the decimal point
//   blank_i : 1 forces the digit fully dark (overrides code and dp)
//   seg_o   : active-low pattern {a,b,c,d,e,f,g,dp}
module bcd_seg_decode
    import seg_pkg::*;
(
    input  logic [3:0] code_i,
    input  logic       dp_i,
    input  logic       blank_i,
    output seg_t       seg_o
);

    seg_t pat_c;

    // Digit lookup, then dp, then blank has the final say
    always_comb begin
        pat_c = SEG_ERR;
        case (code_i)
            4'd0:    pat_c = SEG_0;
            4'd1:    pat_c = SEG_1;
            4'd2:    pat_c = SEG_2;
            4'd3:    pat_c = SEG_3;
            4'd4:    pat_c = SEG_4;
            4'd5:    pat_c = SEG_5;
            4'd6:    pat_c = SEG_6;
            4'd7:    pat_c = SEG_7;
            4'd8:    pat_c = SEG_8;
            4'd9:    pat_c = SEG_9;
            default: pat_c = SEG_ERR;
        endcase
        if (dp_i) begin
            pat_c[SEG_DP_BIT] = 1'b0;
        end
        if (blank_i) begin
            pat_c = SEG_BLANK;
        end
    end

    assign seg_o = pat_c;

endmodule

// File: rtl/bcd_seg_scanner.sv
// Time-multiplexed driver for a common-anode multi-digit 7-segment display.
// Inputs are latched into shadow registers once per frame so a frame never tears.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   BCD_code   : packed BCD digits, digit i = BCD_code[4i+3:4i], digit 0 rightmost
//   dp_in      : per-digit decimal point, 1 = lit
//   blank_in   : per-digit blank, 1 = dark
//   seg_out    : registered active-low segments {a..g,dp}
//   seg_sel    : registered digit enables, polarity set by SEL_ACTIVE_LOW
//   frame_done : registered one-cycle pulse after the last digit's slot ends
module bcd_seg_scanner
    import seg_pkg::*;
#(
    parameter int unsigned NUM_DIGITS     = 4,
    parameter int unsigned SCAN_DIV       = 50000,
    parameter int unsigned DEAD_CYC       = 2,
    parameter bit          SEL_ACTIVE_LOW = 1'b1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [4*NUM_DIGITS-1:0]   BCD_code,
    input  logic [NUM_DIGITS-1:0]     dp_in,
    input  logic [NUM_DIGITS-1:0]     blank_in,
    output logic [SEG_W-1:0]          seg_out,
    output logic [NUM_DIGITS-1:0]     seg_sel,
    output logic                      frame_done
);

    localparam int unsigned TICK_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int unsigned IDX_W  = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam logic [TICK_W-1:0]     TICK_LAST = TICK_W'(SCAN_DIV - 1);
    localparam logic [IDX_W-1:0]      IDX_LAST  = IDX_W'(NUM_DIGITS - 1);
    localparam logic [NUM_DIGITS-1:0] SEL_OFF   = {NUM_DIGITS{SEL_ACTIVE_LOW}};

    logic [TICK_W-1:0]       tick_q, tick_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic                    prime_q, prime_d;
    logic [4*NUM_DIGITS-1:0] code_sh_q, code_sh_d;
    logic [NUM_DIGITS-1:0]   dp_sh_q, dp_sh_d;
    logic [NUM_DIGITS-1:0]   blank_sh_q, blank_sh_d;
    seg_t                    seg_out_q, seg_out_d;
    logic [NUM_DIGITS-1:0]   seg_sel_q, seg_sel_d;
    logic                    frame_done_q, frame_done_d;

    logic                    slot_end_c, frame_wrap_c, load_c, dead_c;
    logic [3:0]              dig_code_c;
    logic                    dig_dp_c, dig_blank_c;
    logic [NUM_DIGITS-1:0]   onehot_c;
    seg_t                    dec_seg_c;

    bcd_seg_decode u_decode (
        .code_i  (dig_code_c),
        .dp_i    (dig_dp_c),
        .blank_i (dig_blank_c),
        .seg_o   (dec_seg_c)
    );

    // Scan counters, frame-synchronous input latching and output gating
    always_comb begin
        tick_d       = tick_q;
        idx_d        = idx_q;
        prime_d      = 1'b0;
        code_sh_d    = code_sh_q;
        dp_sh_d      = dp_sh_q;
        blank_sh_d   = blank_sh_q;
        dig_code_c   = 4'd0;
        dig_dp_c     = 1'b0;
        dig_blank_c  = 1'b1;
        onehot_c     = '0;

        slot_end_c   = (tick_q == TICK_LAST);
        frame_wrap_c = slot_end_c && (idx_q == IDX_LAST) && !prime_q;
        load_c       = prime_q || frame_wrap_c;

        // Counters hold during the prime cycle so digit 0 starts at tick 0 with fresh data
        if (!prime_q) begin
            if (slot_end_c) begin
                tick_d = '0;
                idx_d  = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
            end else begin
                tick_d = tick_q + TICK_W'(1);
            end
        end

        if (load_c) begin
            code_sh_d  = BCD_code;
            dp_sh_d    = dp_in;
            blank_sh_d = blank_in;
        end

        for (int i = 0; i < int'(NUM_DIGITS); i++) begin
            if (idx_q == IDX_W'(i)) begin
                dig_code_c  = code_sh_q[4*i +: 4];
                dig_dp_c    = dp_sh_q[i];
                dig_blank_c = blank_sh_q[i];
                onehot_c[i] = 1'b1;
            end
        end

        dead_c       = prime_q || (32'(tick_q) < DEAD_CYC);
        seg_out_d    = dead_c ? SEG_BLANK : dec_seg_c;
        seg_sel_d    = dead_c ? SEL_OFF : (onehot_c ^ SEL_OFF);
        frame_done_d = frame_wrap_c;
    end

    // State and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            tick_q       <= '0;
            idx_q        <= '0;
            prime_q      <= 1'b1;
            code_sh_q    <= '0;
            dp_sh_q      <= '0;
            blank_sh_q   <= '1;
            seg_out_q    <= SEG_BLANK;
            seg_sel_q    <= SEL_OFF;
            frame_done_q <= 1'b0;
        end else begin
            tick_q       <= tick_d;
            idx_q        <= idx_d;
            prime_q      <= prime_d;
            code_sh_q    <= code_sh_d;
            dp_sh_q      <= dp_sh_d;
            blank_sh_q   <= blank_sh_d;
            seg_out_q    <= seg_out_d;
            seg_sel_q    <= seg_sel_d;
            frame_done_q <= frame_done_d;
        end
    end

    assign seg_out    = seg_out_q;
    assign seg_sel    = seg_sel_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_seg_scanner.sv
// Self-checking bench for bcd_seg_scanner (4 digits, 4-cycle slots, 1 dead cycle, active-low selects).
module tb_bcd_seg_scanner;

    logic        clk;
    logic        rst;
    logic [15:0] BCD_code;
    logic [3:0]  dp_in;
    logic [3:0]  blank_in;
    logic [7:0]  seg_out;
    logic [3:0]  seg_sel;
    logic        frame_done;

    int checks;
    int errors;
    int cyc;

    bcd_seg_scanner #(
        .NUM_DIGITS     (4),
        .SCAN_DIV       (4),
        .DEAD_CYC       (1),
        .SEL_ACTIVE_LOW (1'b1)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .BCD_code   (BCD_code),
        .dp_in      (dp_in),
        .blank_in   (blank_in),
        .seg_out    (seg_out),
        .seg_sel    (seg_sel),
        .frame_done (frame_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] code;
        logic [3:0]  dp;
        logic [3:0]  blank;
        int          slot;
        logic [7:0]  seg;
        logic [3:0]  sel;
    } vec_t;

    vec_t vecs[16];

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s @cyc %0d: got %b expected %b", name, cyc, got, exp);
        end
    endtask

    // One clock edge, sampled 1 time unit later
    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic goto(input int c);
        while (cyc < c) step();
    endtask

    // Apply inputs, pulse reset for one edge, and release; cyc=1 is the prime-load edge
    task automatic restart(input logic [15:0] code, input logic [3:0] dp, input logic [3:0] blank);
        BCD_code = code;
        dp_in    = dp;
        blank_in = blank;
        rst      = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        cyc      = 0;
        rst      = 1'b1;
        BCD_code = 16'h4321;
        dp_in    = 4'b0000;
        blank_in = 4'b0000;

        vecs[0]  = '{16'h4321, 4'b0000, 4'b0000, 0, 8'b10011111, 4'b1110};
        vecs[1]  = '{16'h4321, 4'b0000, 4'b0000, 1, 8'b00100101, 4'b1101};
        vecs[2]  = '{16'h4321, 4'b0000, 4'b0000, 2, 8'b00001101, 4'b1011};
        vecs[3]  = '{16'h4321, 4'b0000, 4'b0000, 3, 8'b10011001, 4'b0111};
        vecs[4]  = '{16'h9B21, 4'b1000, 4'b0000, 2, 8'b01100001, 4'b1011};
        vecs[5]  = '{16'h9B21, 4'b1000, 4'b0000, 3, 8'b00011000, 4'b0111};
        vecs[6]  = '{16'h4321, 4'b0000, 4'b0100, 2, 8'b11111111, 4'b1011};
        vecs[7]  = '{16'h4321, 4'b0000, 4'b0100, 1, 8'b00100101, 4'b1101};
        vecs[8]  = '{16'h4321, 4'b0000, 4'b0100, 3, 8'b10011001, 4'b0111};
        vecs[9]  = '{16'h8765, 4'b0000, 4'b0000, 0, 8'b01001001, 4'b1110};
        vecs[10] = '{16'h6F70, 4'b0001, 4'b0000, 0, 8'b00000010, 4'b1110};
        vecs[11] = '{16'h6F70, 4'b0000, 4'b0000, 1, 8'b00011111, 4'b1101};
        vecs[12] = '{16'h6F70, 4'b0000, 4'b0000, 2, 8'b01100001, 4'b1011};
        vecs[13] = '{16'h6F70, 4'b0000, 4'b0000, 3, 8'b01000001, 4'b0111};
        vecs[14] = '{16'h0008, 4'b0001, 4'b0001, 0, 8'b11111111, 4'b1110};
        vecs[15] = '{16'h0008, 4'b0000, 4'b0000, 0, 8'b00000001, 4'b1110};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("reset_seg", 16'(seg_out), 16'hFF);
        chk("reset_sel", 16'(seg_sel), 16'hF);
        chk("reset_fd",  16'(frame_done), 16'h0);

        // Table: slot s is dark at cyc 4s+2 and shows its digit at 4s+3..4s+5
        for (int v = 0; v < 16; v++) begin
            restart(vecs[v].code, vecs[v].dp, vecs[v].blank);
            goto(4*vecs[v].slot + 2);
            chk("dead_seg", 16'(seg_out), 16'hFF);
            chk("dead_sel", 16'(seg_sel), 16'hF);
            goto(4*vecs[v].slot + 3);
            chk("slot_seg_first", 16'(seg_out), 16'(vecs[v].seg));
            chk("slot_sel_first", 16'(seg_sel), 16'(vecs[v].sel));
            goto(4*vecs[v].slot + 5);
            chk("slot_seg_last", 16'(seg_out), 16'(vecs[v].seg));
            chk("slot_sel_last", 16'(seg_sel), 16'(vecs[v].sel));
        end

        // Output stays dark through the prime cycle, frame_done pulses at cyc 17 and 33
        restart(16'h4321, 4'b0000, 4'b0000);
        step();
        chk("prime_seg", 16'(seg_out), 16'hFF);
        chk("prime_sel", 16'(seg_sel), 16'hF);
        for (int c = 2; c <= 40; c++) begin
            step();
            chk("frame_done", 16'(frame_done), (c == 17 || c == 33) ? 16'h1 : 16'h0);
        end

        // Mid-frame input change is held off until the next frame wrap
        restart(16'h4321, 4'b0000, 4'b0000);
        goto(7);
        BCD_code = 16'h8765;
        goto(9);
        chk("hold_slot1", 16'(seg_out), 16'b00100101);
        goto(11);
        chk("hold_slot2", 16'(seg_out), 16'b00001101);
        goto(15);
        chk("hold_slot3", 16'(seg_out), 16'b10011001);
        goto(19);
        chk("new_slot0", 16'(seg_out), 16'b01001001);
        chk("new_slot0_sel", 16'(seg_sel), 16'hE);

        // Change one cycle after the load edge is not captured until the frame after
        restart(16'h4321, 4'b0000, 4'b0000);
        goto(17);
        BCD_code = 16'h8765;
        goto(19);
        chk("late_change_old", 16'(seg_out), 16'b10011111);
        goto(35);
        chk("late_change_new", 16'(seg_out), 16'b01001001);

        // Change coincident with the load edge wins
        restart(16'h4321, 4'b0000, 4'b0000);
        goto(16);
        BCD_code = 16'h8765;
        goto(19);
        chk("coincident_new", 16'(seg_out), 16'b01001001);

        // Reset mid-slot 2 aborts the scan; restart primes the new inputs
        restart(16'h4321, 4'b0000, 4'b0000);
        goto(12);
        chk("pre_rst_seg", 16'(seg_out), 16'b00001101);
        rst      = 1'b1;
        BCD_code = 16'h8765;
        step();
        chk("mid_rst_seg", 16'(seg_out), 16'hFF);
        chk("mid_rst_sel", 16'(seg_sel), 16'hF);
        chk("mid_rst_fd",  16'(frame_done), 16'h0);
        rst = 1'b0;
        cyc = 0;
        goto(2);
        chk("restart_dead", 16'(seg_out), 16'hFF);
        goto(3);
        chk("restart_seg", 16'(seg_out), 16'b01001001);
        chk("restart_sel", 16'(seg_sel), 16'hE);

        // Random inputs and occasional resets: at most one select active, no X on segments
        for (int n = 0; n < 1000; n++) begin
            BCD_code = 16'($urandom);
            dp_in    = 4'($urandom);
            blank_in = 4'($urandom);
            rst      = ($urandom_range(0, 49) == 0);
            step();
            chk("sel_onehot", 16'($countones(~seg_sel) <= 1), 16'h1);
            chk("seg_known",  16'(!$isunknown(seg_out)), 16'h1);
        end
        rst = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    // Global time limit
    initial begin
        #2000000;
        $display("FAIL timeout: simulation did not complete, got hang expected finish");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/bcd_seg_scanner.md
# bcd_seg_scanner

Parametrised, time-multiplexed driver for a common-anode multi-digit 7-segment display. It accepts NUM_DIGITS packed BCD digits with per-digit decimal-point and blank controls, and latches them once per scan frame so no digit tears mid-frame. It scans one digit per slot and drives registered active-low segment and digit-select lines directly to the board pins. It sits between the game-state/score logic and the display connector, replacing per-digit static decoding.

## Interface
- NUM_DIGITS, 4, number of digits scanned; legal 1..8
- SCAN_DIV, 50000, clock cycles per digit slot; legal >= DEAD_CYC+1
- DEAD_CYC, 2, cycles at the start of each slot during which segments and selects are all off (anti-ghosting); legal >= 0
- SEL_ACTIVE_LOW, 1, 1: selected digit drives 0; 0: selected digit drives 1
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- BCD_code  in  4*NUM_DIGITS  packed digits; digit i = BCD_code[4i+3:4i]; digit 0 is rightmost
- dp_in  in  NUM_DIGITS  decimal point per digit, 1 = lit
- blank_in  in  NUM_DIGITS  1 = digit dark regardless of code and dp
- seg_out  out  8  active-low segments {a,b,c,d,e,f,g,dp}, bit 7 = a, bit 0 = dp
- seg_sel  out  NUM_DIGITS  digit enables, polarity per SEL_ACTIVE_LOW; at most one active
- frame_done  out  1  one-cycle pulse when the last digit's slot ends

## Operation
- Decode per digit, active-low: 0=00000011, 1=10011111, 2=00100101, 3=00001101, 4=10011001, 5=01001001, 6=01000001, 7=00011111, 8=00000001, 9=00011001.
- Codes 10..15 display the error glyph "E" = 01100001; never X.
- dp_in[i]=1 clears bit 0 of that digit's pattern.
- blank_in[i]=1 forces the pattern to 11111111; the digit's select still follows the scan.
- Counters:
  - tick counts 0..SCAN_DIV-1, width max(1,$clog2(SCAN_DIV)).
  - idx counts 0..NUM_DIGITS-1, width max(1,$clog2(NUM_DIGITS)).
  - idx advances when tick==SCAN_DIV-1 and wraps from NUM_DIGITS-1 to 0.
- Shadow registers (code, dp, blank) load all inputs in the same cycle:
  - on the first cycle after rst deasserts (prime flag);
  - at every frame wrap (tick==SCAN_DIV-1 and idx==NUM_DIGITS-1).
  - Input changes at any other time are invisible until the next load.
- frame_done is asserted in the cycle after a frame wrap, for exactly 1 cycle.
- Dead time: while tick < DEAD_CYC, seg_out=11111111 and all seg_sel inactive.
- Otherwise seg_sel activates bit idx only, and seg_out shows the shadow pattern for digit idx.
- NUM_DIGITS=1: idx stays 0, and every slot end is a frame wrap.

## Timing
- Reset (rst high at a clock edge) gives, in the following cycle:
  - tick=0, idx=0, shadow blank=all 1, prime=1;
  - seg_out=11111111, seg_sel all inactive, frame_done=0.
- rst asserted mid-frame aborts the scan at the next edge. Output is dark until the prime load, then digit 0 restarts from tick 0.
- All outputs are registered. seg_out, seg_sel and frame_done reflect the tick/idx/shadow state of the previous cycle (1-cycle latency).
- Input sampled at load edge N appears on seg_out no earlier than edge N+1+DEAD_CYC for digit 0.
- Input change coincident with a load edge is captured (new value wins).
- Frame period = NUM_DIGITS*SCAN_DIV cycles exactly; no gaps between slots.

## Structure
- Package seg_pkg holds:
  - SEG_0..SEG_9, SEG_ERR (01100001) and SEG_BLANK (11111111) 8-bit constants;
  - the segment bit-order definition.
- Sub-module bcd_seg_decode:
  - combinational; inputs 4-bit code, dp, blank; output 8-bit active-low pattern;
  - uses seg_pkg;
  - instantiated once on the shadow digit selected by idx.
- Top holds the counters, shadow registers, prime flag, dead-time gating and output registers.

## Test plan
All scenarios use NUM_DIGITS=4, SCAN_DIV=4, DEAD_CYC=1, SEL_ACTIVE_LOW=1.
- Reset, then BCD_code=16'h4321, dp_in=0, blank_in=0 held:
  - per 4-cycle slot, 1 dark cycle, then 3 cycles of the digit;
  - digit 0: seg_sel=1110, seg_out=10011111; digit 1: seg_sel=1101, seg_out=00100101;
  - frame_done pulses every 16 cycles.
- BCD_code digit 2 = 4'hB -> seg_out=01100001 in slot 2; digit 3 = 4'h9 with dp_in[3]=1 -> seg_out=00011000.
- blank_in=4'b0100 -> seg_sel=1011 with seg_out=11111111 in slot 2; other slots unaffected.
- Change BCD_code from 16'h4321 to 16'h8765 during slot 1 -> slots 1..3 still show 2,3,4; the new digits appear from the next frame's digit 0 (seg_out=01001001).
- Assert rst for 1 cycle mid-slot 2 -> next cycle seg_out=11111111 and seg_sel=1111; the scan restarts at digit 0 with freshly primed inputs.
- Over 1000 random-input cycles, check the invariants:
  - seg_sel never has more than one active bit;
  - seg_out is never X.
